// File: rtl/muldiv_seq_ctrl_pkg.sv
// rtl/muldiv_seq_ctrl_pkg.sv - shared encodings and defaults for the HI/LO sequencer
//
// Purpose : op encodings, sequencer state encoding and divider timeout defaults
//           shared by the sequencer, its timeout counter and the bench.
// Ports   : none (package).
package muldiv_seq_ctrl_pkg;

   typedef enum logic [2:0] {
      MD_NONE  = 3'd0,
      MD_MULT  = 3'd1,
      MD_MULTU = 3'd2,
      MD_DIV   = 3'd3,
      MD_DIVU  = 3'd4,
      MD_MTHI  = 3'd5,
      MD_MTLO  = 3'd6,
      MD_RSVD  = 3'd7
   } md_op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2,
      S_HELD = 2'd3
   } md_state_e;

   localparam int DIV_TIMEOUT_DEF = 40;
   localparam int CNT_W_DEF       = 6;

endpackage

// File: rtl/muldiv_seq_ctrl_if.sv
// rtl/muldiv_seq_ctrl_if.sv - sequencer <-> iterative divider channel
//
// Purpose : bundles the divider start/abort/operand/result handshake.
// Ports   : master = sequencer (drives start, signed, operands, annul;
//           receives result and ready); slave = divider.
interface muldiv_seq_ctrl_if;

   logic        div_start_o;
   logic        div_signed_o;
   logic [31:0] div_op1_o;
   logic [31:0] div_op2_o;
   logic        div_annul_o;
   logic [63:0] div_result_i;
   logic        div_ready_i;

   modport master (
      output div_start_o, div_signed_o, div_op1_o, div_op2_o, div_annul_o,
      input  div_result_i, div_ready_i
   );

   modport slave (
      input  div_start_o, div_signed_o, div_op1_o, div_op2_o, div_annul_o,
      output div_result_i, div_ready_i
   );

endinterface

// File: rtl/md_timeout_cnt.sv
// rtl/md_timeout_cnt.sv - RUN cycle counter with divider timeout compare
//
// Purpose : counts cycles spent waiting on the divider; flags the last
//           allowed cycle so the sequencer can abort.
// Ports   : clk, rstn (async, active-low); clr_i zeroes the count; en_i
//           counts one cycle; expired_o high on the DIV_TIMEOUT-th enabled
//           cycle after a clear.
module md_timeout_cnt
   import muldiv_seq_ctrl_pkg::*;
#(
   parameter int DIV_TIMEOUT = DIV_TIMEOUT_DEF,
   parameter int CNT_W       = CNT_W_DEF
) (
   input  logic clk,
   input  logic rstn,
   input  logic clr_i,
   input  logic en_i,
   output logic expired_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Count starts at 0 on the first RUN cycle, so DIV_TIMEOUT-1 marks the
   // DIV_TIMEOUT-th cycle spent waiting.
   assign expired_o = en_i && (cnt_q == CNT_W'(DIV_TIMEOUT - 1));

endmodule

// File: rtl/muldiv_seq_ctrl.sv
// rtl/muldiv_seq_ctrl.sv - execute-stage HI/LO write and divide sequencer
//
// Purpose : single-cycle HI/LO writes for MULT/MULTU/MTHI/MTLO; starts and
//           supervises the external iterative divider, stalling EX until
//           the result commits exactly once; handles flush, hold,
//           divide-by-zero and divider timeout.
// Ports   : clk, rstn (async, active-low)
//           op_valid_i/op_i/src1_i/src2_i - EX instruction and operands
//           mul_res_i - combinational product; hi_cur_i/lo_cur_i - HI/LO now
//           ex_hold_i - downstream stall; flush_i - kill EX and divide
//           div_if (master) - divider channel
//           hilo_we_o/hi_o/lo_o - HI/LO write port
//           stall_o, busy_o, err_o - pipeline freeze, not idle, timeout pulse
module muldiv_seq_ctrl
   import muldiv_seq_ctrl_pkg::*;
#(
   parameter int DIV_TIMEOUT = DIV_TIMEOUT_DEF,
   parameter int CNT_W       = CNT_W_DEF
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  op_valid_i,
   input  logic [2:0]            op_i,
   input  logic [31:0]           src1_i,
   input  logic [31:0]           src2_i,
   input  logic [63:0]           mul_res_i,
   input  logic [31:0]           hi_cur_i,
   input  logic [31:0]           lo_cur_i,
   input  logic                  ex_hold_i,
   input  logic                  flush_i,
   muldiv_seq_ctrl_if.master     div_if,
   output logic                  hilo_we_o,
   output logic [31:0]           hi_o,
   output logic [31:0]           lo_o,
   output logic                  stall_o,
   output logic                  busy_o,
   output logic                  err_o
);

   md_state_e   state_q, state_d;
   logic        signed_q, signed_d;
   logic [31:0] op1_q, op1_d;
   logic [31:0] op2_q, op2_d;
   logic [63:0] res_q, res_d;

   md_op_e      op;
   logic        cnt_clr;
   logic        expired;
   logic        annul;

   assign op = md_op_e'(op_i);

   md_timeout_cnt #(
      .DIV_TIMEOUT (DIV_TIMEOUT),
      .CNT_W       (CNT_W)
   ) u_timeout_cnt (
      .clk       (clk),
      .rstn      (rstn),
      .clr_i     (cnt_clr),
      .en_i      (state_q == S_RUN),
      .expired_o (expired)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q  <= S_IDLE;
         signed_q <= 1'b0;
         op1_q    <= '0;
         op2_q    <= '0;
         res_q    <= '0;
      end else begin
         state_q  <= state_d;
         signed_q <= signed_d;
         op1_q    <= op1_d;
         op2_q    <= op2_d;
         res_q    <= res_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      signed_d  = signed_q;
      op1_d     = op1_q;
      op2_d     = op2_q;
      res_d     = res_q;
      cnt_clr   = 1'b0;
      annul     = 1'b0;
      hilo_we_o = 1'b0;
      hi_o      = '0;
      lo_o      = '0;
      stall_o   = 1'b0;
      err_o     = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (op_valid_i && !flush_i) begin
               case (op)
                  MD_MULT, MD_MULTU: begin
                     if (!ex_hold_i) begin
                        hilo_we_o    = 1'b1;
                        {hi_o, lo_o} = mul_res_i;
                     end
                  end
                  MD_MTHI: begin
                     if (!ex_hold_i) begin
                        hilo_we_o = 1'b1;
                        hi_o      = src1_i;
                        lo_o      = lo_cur_i;
                     end
                  end
                  MD_MTLO: begin
                     if (!ex_hold_i) begin
                        hilo_we_o = 1'b1;
                        hi_o      = hi_cur_i;
                        lo_o      = src1_i;
                     end
                  end
                  MD_DIV, MD_DIVU: begin
                     // Zero divisor retires as a no-op: HI/LO stay untouched.
                     // Stall is raised even under hold so EX cannot slip
                     // past a divide that has not started yet.
                     if (src2_i != '0) begin
                        stall_o = 1'b1;
                        if (!ex_hold_i) begin
                           signed_d = (op == MD_DIV);
                           op1_d    = src1_i;
                           op2_d    = src2_i;
                           cnt_clr  = 1'b1;
                           state_d  = S_RUN;
                        end
                     end
                  end
                  default: ;
               endcase
            end
         end

         S_RUN: begin
            if (flush_i) begin
               // Flush beats a coincident ready: the result is discarded.
               annul   = 1'b1;
               state_d = S_IDLE;
            end else begin
               stall_o = 1'b1;
               if (div_if.div_ready_i) begin
                  res_d   = div_if.div_result_i;
                  state_d = S_DONE;
               end else if (expired) begin
                  annul   = 1'b1;
                  err_o   = 1'b1;
                  state_d = S_HELD;
               end
            end
         end

         S_DONE: begin
            if (flush_i) begin
               state_d = S_IDLE;
            end else begin
               hilo_we_o = 1'b1;
               hi_o      = res_q[63:32];
               lo_o      = res_q[31:0];
               state_d   = ex_hold_i ? S_HELD : S_IDLE;
            end
         end

         S_HELD: begin
            // The retired DIV may still sit in EX; wait it out without re-issue.
            if (flush_i || !ex_hold_i) begin
               state_d = S_IDLE;
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   assign div_if.div_start_o  = (state_q == S_RUN);
   assign div_if.div_signed_o = signed_q;
   assign div_if.div_op1_o    = op1_q;
   assign div_if.div_op2_o    = op2_q;
   assign div_if.div_annul_o  = annul;
   assign busy_o              = (state_q != S_IDLE);

endmodule

// File: doc/muldiv_seq_ctrl.md
Name: muldiv_seq_ctrl

Overview:
Sequencer for the HI/LO datapath in the execute stage. It issues MULT/MULTU/MTHI/MTLO writes to the hilo register in a single cycle. It starts and supervises the iterative divider, holding the pipeline stalled until the quotient and remainder are ready, and commits the result to HI/LO exactly once. It handles pipeline flush and hold, divide-by-zero, and divider timeout.

Parameters:
DIV_TIMEOUT, 40, maximum cycles in RUN awaiting div_ready_i before abort
CNT_W, 6, width of the RUN cycle counter; must satisfy 2^CNT_W > DIV_TIMEOUT

Ports:
clk  in  1  clock
rstn  in  1  reset, asynchronous, active-low
op_valid_i  in  1  EX holds a valid HI/LO-class instruction this cycle
op_i  in  3  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as NONE)
src1_i  in  32  rs operand (dividend / MTHI-MTLO data)
src2_i  in  32  rt operand (divisor)
mul_res_i  in  64  combinational multiplier product {hi,lo}
hi_cur_i  in  32  current HI register value
lo_cur_i  in  32  current LO register value
ex_hold_i  in  1  downstream stall; EX instruction does not advance this cycle
flush_i  in  1  kill the EX instruction and any in-flight divide
div_start_o  out  1  divider start, level, high throughout RUN
div_signed_o  out  1  latched signed-divide flag
div_op1_o  out  32  latched dividend
div_op2_o  out  32  latched divisor
div_annul_o  out  1  divider abort, one-cycle pulse
div_result_i  in  64  {remainder[63:32], quotient[31:0]}
div_ready_i  in  1  divider result valid
hilo_we_o  out  1  HI/LO write enable
hi_o  out  32  HI write data
lo_o  out  32  LO write data
stall_o  out  1  freeze IF/ID/EX
busy_o  out  1  state != IDLE
err_o  out  1  one-cycle pulse on divider timeout

Behaviour:
- Reset: state IDLE. All outputs 0. Latched operands, latched result and counter are 0. Reset mid-divide aborts silently, with no annul pulse.
- "issue" = op_valid_i & !ex_hold_i & !flush_i, evaluated in IDLE only.
- States and transitions:
  - IDLE, MULT/MULTU issue: hilo_we_o=1 in the same cycle. {hi_o,lo_o}=mul_res_i. Stay IDLE.
  - IDLE, MTHI issue: hilo_we_o=1, hi_o=src1_i, lo_o=lo_cur_i.
  - IDLE, MTLO issue: hilo_we_o=1, hi_o=hi_cur_i, lo_o=src1_i.
  - IDLE, DIV/DIVU with op_valid_i & !flush_i & src2_i!=0:
    - stall_o=1 combinationally.
    - If !ex_hold_i: latch src1_i, src2_i and signed flag (DIV=1); clear counter; go to RUN.
  - IDLE, DIV/DIVU with src2_i==0: no start, no stall, no write; HI/LO unchanged.
  - RUN:
    - div_start_o=1, stall_o=1; counter increments each cycle.
    - div_ready_i: latch div_result_i, go to DONE.
    - Counter reaches DIV_TIMEOUT-1 without ready: div_annul_o=1, err_o=1, go to HELD, no write.
  - DONE (exactly 1 cycle):
    - hilo_we_o=1, hi_o=latched remainder, lo_o=latched quotient, stall_o=0.
    - Next state: HELD if ex_hold_i, else IDLE.
  - HELD:
    - stall_o=0, no writes, no re-issue even though the same DIV is still presented.
    - Go to IDLE on the first cycle with !ex_hold_i.
- flush_i has highest priority in every state:
  - In RUN: div_annul_o=1 that cycle, stall_o=0, no write, next state IDLE. This applies even when div_ready_i arrives in the same cycle.
  - In DONE: suppresses hilo_we_o; next state IDLE.
  - In HELD: next state IDLE.
- hilo_we_o is asserted at most once per retired instruction; it is never asserted in RUN or HELD.
- Divider latency is not fixed: any ready arrival at or after RUN cycle 1 is accepted. div_ready_i outside RUN is ignored.
- When hilo_we_o=0, hi_o and lo_o are 0.

Decomposition:
- Shared package/defines header holds:
  - Op encodings (MD_NONE..MD_MTLO).
  - State encoding (S_IDLE, S_RUN, S_DONE, S_HELD).
  - DIV_TIMEOUT default.
- The RUN cycle counter with timeout compare is one natural sub-module: md_timeout_cnt (clear, enable, expired).
- The divider itself stays external.

Test Plan:
- MULT, mul_res_i=0xFFFFFFFF_FFFFFFF7, hold=0 -> same cycle hilo_we_o=1, hi_o=0xFFFFFFFF, lo_o=0xFFFFFFF7, stall_o=0, busy_o=0.
- DIVU 100/7, model ready after 33 cycles with {2,14} -> stall_o high from issue cycle through ready cycle; next cycle hilo_we_o=1, hi_o=2, lo_o=14; exactly one write; IDLE after.
- DIV -7/2 with ex_hold_i=1 from ready cycle for 5 cycles -> one write in DONE, HELD for remaining hold, div_start_o never re-asserts, IDLE when hold drops.
- DIV started, flush_i at RUN cycle 10, and separately flush_i coincident with div_ready_i -> div_annul_o pulse, no hilo_we_o, stall_o=0 that cycle, IDLE next.
- DIV 5/0 -> div_start_o=0, stall_o=0, hilo_we_o=0; MTHI src1=0xDEADBEEF, lo_cur=0x1234 -> hi_o=0xDEADBEEF, lo_o=0x1234.
- DIV with div_ready_i held low -> after DIV_TIMEOUT RUN cycles div_annul_o=1 and err_o=1 for one cycle, no write, HELD then IDLE.
